// File: rtl/pwm_from_count.sv
// PWM generator slaved to an external free-running counter, with a
// double-buffered duty register that is applied only on counter wrap.
module pwm_from_count #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             busy,
    output logic             sync_err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt_prev;
    logic [CNT_W-1:0] r_duty_pend;
    logic [CNT_W-1:0] r_duty_act;
    logic             r_prev_vld;
    logic             r_pend_flag;
    logic             r_pwm;
    logic             r_tick;
    logic             r_sync_err;

    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_duty_eff;
    logic             w_wrap;
    logic             w_disc;
    logic             w_accept;
    logic             w_active;
    logic             w_nxt_active;

    assign w_cnt_inc  = r_cnt_prev + CNT_W'(1);
    assign w_wrap     = r_prev_vld && (r_cnt_prev == MAX) && (cnt == '0);
    assign w_disc     = r_prev_vld && (cnt != w_cnt_inc);
    assign w_accept   = duty_valid && !r_pend_flag;
    // A duty that is being promoted on this wrap must already shape this period.
    assign w_duty_eff = (w_wrap && r_pend_flag) ? r_duty_pend : r_duty_act;
    assign w_active     = (r_state == RUN) || (r_state == STOP);
    assign w_nxt_active = (w_state_nxt == RUN) || (w_state_nxt == STOP);

    assign duty_ready  = ~r_pend_flag;
    assign pwm_out     = r_pwm;
    assign period_tick = r_tick;
    assign busy        = (r_state != IDLE);
    assign sync_err    = r_sync_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (en) w_state_nxt = ARM;
            ARM: begin
                if (!en)        w_state_nxt = IDLE;
                else if (w_wrap) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_disc)     w_state_nxt = ARM;
                else if (!en)   w_state_nxt = w_wrap ? IDLE : STOP;
            end
            STOP: begin
                if (w_disc)      w_state_nxt = ARM;
                else if (w_wrap) w_state_nxt = IDLE;
                else if (en)     w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt_prev  <= '0;
            r_prev_vld  <= 1'b0;
            r_duty_pend <= '0;
            r_duty_act  <= '0;
            r_pend_flag <= 1'b0;
            r_pwm       <= 1'b0;
            r_tick      <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt_prev <= cnt;
            r_prev_vld <= 1'b1;
            if (w_disc) r_sync_err <= 1'b1;
            // Accept is blocked while pending, so promote and accept never collide.
            if (w_wrap && r_pend_flag) begin
                r_duty_act  <= r_duty_pend;
                r_pend_flag <= 1'b0;
            end else if (w_accept) begin
                r_duty_pend <= duty_in;
                r_pend_flag <= 1'b1;
            end
            r_pwm  <= w_nxt_active && (cnt < w_duty_eff);
            r_tick <= w_wrap && w_active;
        end
    end

endmodule

// File: tb/tb_pwm_from_count.sv
// Directed bench for pwm_from_count: stimulus queues hand-computed output
// vectors {pwm_out, period_tick, busy, duty_ready, sync_err}; a monitor checks them.
module tb_pwm_from_count;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] cnt = '0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] duty_in = '0;
    logic             duty_valid = 1'b0;
    logic             duty_ready;
    logic             pwm_out;
    logic             period_tick;
    logic             busy;
    logic             sync_err;

    typedef struct {
        logic [4:0] exp;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    pwm_from_count #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt),
        .en         (en),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .busy       (busy),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Monitor: every negedge the DUT presents one registered output vector.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [4:0] act;
            e   = q.pop_front();
            act = {pwm_out, period_tick, busy, duty_ready, sync_err};
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s cnt_prev=%0d got pwm/tick/busy/rdy/err=%b expected %b",
                         e.nm, dut.r_cnt_prev, act, e.exp);
            end
        end
    end

    function automatic logic [4:0] v(input bit p, input bit t, input bit b,
                                     input bit r, input bit e);
        return {p, t, b, r, e};
    endfunction

    task automatic step(input bit r, input int c, input bit e, input bit dv,
                        input int din, input logic [4:0] ex, input string nm);
        exp_t item;
        rst        = r;
        cnt        = CNT_W'(c);
        en         = e;
        duty_valid = dv;
        duty_in    = CNT_W'(din);
        item.exp   = ex;
        item.nm    = nm;
        q.push_back(item);
        @(posedge clk);
        #1;
    endtask

    // Plain counting run with no duty writes: pwm high while c < d.
    task automatic seg(input int lo, input int hi, input bit e, input int d,
                       input bit b, input bit rdy, input bit er, input string nm);
        for (int c = lo; c <= hi; c++)
            step(1'b1, c, e, 1'b0, 0, v(c < d, 1'b0, b, rdy, er), nm);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, v(0,0,0,1,0), "reset");
        step(0, 0, 0, 0, 0, v(0,0,0,1,0), "reset");
        // duty 5 accepted in IDLE, enable, run from first wrap
        step(1, 10, 0, 1, 5, v(0,0,0,0,0), "accept_idle");
        seg(11, 15, 1, 0, 1, 0, 0, "arm");
        step(1, 0, 1, 0, 0, v(1,0,1,1,0), "arm_to_run");
        seg(1, 15, 1, 5, 1, 1, 0, "run5");
        step(1, 0, 1, 0, 0, v(1,1,1,1,0), "tick5");
        seg(1, 2, 1, 5, 1, 1, 0, "run5");
        // mid-period update to 12 waits for the wrap
        step(1, 3, 1, 1, 12, v(1,0,1,0,0), "accept12");
        seg(4, 15, 1, 5, 1, 0, 0, "hold5");
        step(1, 0, 1, 0, 0, v(1,1,1,1,0), "apply12");
        seg(1, 1, 1, 12, 1, 1, 0, "run12");
        // second write while pending is dropped
        step(1, 2, 1, 1, 10, v(1,0,1,0,0), "accept10");
        seg(3, 4, 1, 12, 1, 0, 0, "run12");
        step(1, 5, 1, 1, 3, v(1,0,1,0,0), "ignore3");
        seg(6, 15, 1, 12, 1, 0, 0, "run12");
        step(1, 0, 1, 0, 0, v(1,1,1,1,0), "apply10");
        seg(1, 6, 1, 10, 1, 1, 0, "run10");
        // drop en at cnt=7: STOP finishes the period, then IDLE
        step(1, 7, 0, 0, 0, v(1,0,1,1,0), "stop");
        seg(8, 15, 0, 10, 1, 1, 0, "stop_run_out");
        step(1, 0, 0, 0, 0, v(0,1,0,1,0), "stop_idle");
        seg(1, 3, 0, 0, 0, 1, 0, "idle");
        // duty MAX then duty 0
        step(1, 4, 1, 1, 15, v(0,0,1,0,0), "arm15");
        seg(5, 15, 1, 0, 1, 0, 0, "arm15");
        step(1, 0, 1, 0, 0, v(1,0,1,1,0), "run15");
        seg(1, 2, 1, 15, 1, 1, 0, "run15");
        step(1, 3, 1, 1, 0, v(1,0,1,0,0), "accept0");
        seg(4, 15, 1, 15, 1, 0, 0, "duty_max");
        step(1, 0, 1, 0, 0, v(0,1,1,1,0), "duty_zero");
        seg(1, 3, 1, 0, 1, 1, 0, "duty_zero");
        step(1, 4, 1, 1, 8, v(0,0,1,0,0), "accept8");
        seg(5, 15, 1, 0, 1, 0, 0, "duty_zero");
        step(1, 0, 1, 0, 0, v(1,1,1,1,0), "apply8");
        seg(1, 6, 1, 8, 1, 1, 0, "run8");
        // count jump 6->9: sticky error, re-arm, resume on next wrap
        step(1, 9, 1, 0, 0, v(0,0,1,1,1), "jump");
        seg(10, 15, 1, 0, 1, 1, 1, "arm_err");
        step(1, 0, 1, 0, 0, v(1,0,1,1,1), "resume");
        seg(1, 15, 1, 8, 1, 1, 1, "run8_err");
        step(1, 0, 1, 0, 0, v(1,1,1,1,1), "tick8");
        seg(1, 1, 1, 8, 1, 1, 1, "run8_err");
        // one-cycle reset with a pending duty: it must never appear
        step(1, 2, 1, 1, 1, v(1,0,1,0,1), "accept1");
        seg(3, 4, 1, 8, 1, 0, 1, "pend1");
        step(0, 5, 1, 0, 0, v(0,0,0,1,0), "midreset");
        seg(6, 15, 1, 0, 1, 1, 0, "rearm");
        step(1, 0, 1, 0, 0, v(0,0,1,1,0), "no_stale");
        seg(1, 15, 1, 0, 1, 1, 0, "no_stale");
        // en low exactly on a wrap in RUN goes straight to IDLE with a tick
        step(1, 0, 0, 0, 0, v(0,1,0,1,0), "run_idle_wrap");
        seg(1, 2, 0, 0, 0, 1, 0, "idle");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain queued=%0d expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_from_count.md
PWM_FROM_COUNT -- requirements
Module: pwm_from_count

Interface
REQ-001 Parameter CNT_W, default 4: width of the free-running count input. MAX = 2^CNT_W-1.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-low.
REQ-004 Port cnt, input, CNT_W: count value from the upstream free-running up counter; increments by 1 per clk and wraps MAX->0.
REQ-005 Port en, input, 1: run request; level-sensitive.
REQ-006 Port duty_in, input, CNT_W: requested duty (high cycles per period).
REQ-007 Port duty_valid, input, 1: duty_in valid this cycle.
REQ-008 Port duty_ready, output, 1: block can accept a duty update.
REQ-009 Port pwm_out, output, 1: registered PWM output.
REQ-010 Port period_tick, output, 1: one-cycle pulse per completed period while active.
REQ-011 Port busy, output, 1: high in any state other than IDLE.
REQ-012 Port sync_err, output, 1: sticky flag for a count discontinuity.

Function
REQ-013 Registered cnt_prev and prev_vld SHALL be held; prev_vld is set 1 on the first cycle after reset release.
REQ-014 Wrap SHALL be detected when prev_vld=1, cnt_prev=MAX and cnt=0.
REQ-015 Discontinuity SHALL be detected when prev_vld=1 and cnt != (cnt_prev+1) mod 2^CNT_W.
REQ-016 sync_err SHALL be set on discontinuity; it is cleared only by reset.
REQ-017 Duty SHALL be double-buffered in two registers: duty_pend (plus pend_flag) and duty_act.
REQ-018 duty_ready SHALL equal ~pend_flag (combinational).
REQ-019 On duty_valid & duty_ready: duty_pend<=duty_in, pend_flag<=1.
REQ-020 duty_valid while duty_ready=0 SHALL be ignored; duty_pend is not overwritten.
REQ-021 On wrap with pend_flag=1: duty_act<=duty_pend, pend_flag<=0.
REQ-022 Accept and wrap in the same cycle with pend_flag=0: the new value goes to duty_pend and is applied at the next wrap.
REQ-023 FSM states SHALL be IDLE, ARM, RUN, STOP.
REQ-024 IDLE->ARM when en=1.
REQ-025 ARM->RUN on wrap. ARM->IDLE if en=0.
REQ-026 RUN->STOP when en=0 and no wrap this cycle. RUN with en=0 on a wrap cycle goes directly ->IDLE.
REQ-027 STOP->IDLE on wrap. STOP->RUN if en returns to 1 before the wrap.
REQ-028 RUN or STOP ->ARM on discontinuity, which takes precedence over all other transitions.
REQ-029 pwm_out SHALL be registered: next value = (next_state is RUN or STOP) and (cnt < duty_eff).
- duty_eff = duty_pend on a wrap cycle with pend_flag=1, else duty_act.
- Latency from cnt to pwm_out: one cycle.
REQ-030 duty=0 SHALL give pwm_out constantly 0; duty=MAX SHALL give MAX high cycles out of MAX+1.
REQ-031 period_tick SHALL be registered, high for one cycle after each wrap detected in RUN or STOP; it also fires on the STOP->IDLE wrap and the RUN->IDLE wrap.
REQ-032 busy SHALL be 1 whenever state != IDLE.

Reset
REQ-033 While rst=0 at a clock edge, the following SHALL be applied:
- state=IDLE, duty_act=0, duty_pend=0, pend_flag=0.
- cnt_prev=0, prev_vld=0, pwm_out=0, period_tick=0, sync_err=0.
REQ-034 Reset asserted mid-operation SHALL take effect at the next edge and discard any pending duty update; duty_ready=1 on the first cycle after release.

Verification
REQ-035 Continuous cnt, duty_in=5 accepted in IDLE, en=1 -> RUN after the first 15->0 wrap; pwm_out high 5 cycles, low 11, per 16-cycle period; period_tick every 16 cycles.
REQ-036 Mid-period write duty=12 while running at 5 -> current period stays 5 high; next period 12 high; duty_ready=0 from the accept until the wrap.
REQ-037 Second duty_valid (value 3) while pend_flag=1 -> ignored; duty_act becomes the first value, never 3.
REQ-038 Drop en at cnt=7 in RUN -> STOP, period completes, one period_tick, IDLE, pwm_out=0, busy=0.
REQ-039 cnt jumps 6->9 in RUN -> sync_err=1 next cycle and held; state ARM, pwm_out=0 until the next wrap, then RUN resumes.
REQ-040 rst=0 for one cycle during RUN with pend_flag=1 -> all outputs 0, duty_ready=1, state IDLE; the pending duty is never applied.
